vc_demux_pop: RTL

VC_DEMUX_POP -- requirements
Module: vc_demux_pop

---
 rtl/vc_demux_pop_pkg.sv | 13 +
 rtl/vc_skid_reg.sv | 55 +++++
 rtl/vc_demux_pop.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vc_demux_pop_pkg.sv
// Shared transmission-layer definitions: default word width and FSM encodings.
package vc_demux_pop_pkg;

  localparam int unsigned DW_DEFAULT = 6;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } vc_state_e;

endpackage

// File: rtl/vc_skid_reg.sv
// One-entry skid buffer holding a word whose destination VC was full.
module vc_skid_reg
  import vc_demux_pop_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          drain,
  input  logic [DW-1:0] load_data,
  output logic [DW-1:0] data,
  output logic          vld,
  output logic          tgt
);

  logic [DW-1:0] data_q, data_d;
  logic          vld_q, vld_d;
  logic          tgt_q, tgt_d;

  // Load captures word and its routing bit; drain empties the entry.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    tgt_d  = tgt_q;
    if (drain) begin
      data_d = '0;
      vld_d  = 1'b0;
      tgt_d  = 1'b0;
    end
    if (load) begin
      data_d = load_data;
      vld_d  = 1'b1;
      tgt_d  = load_data[DW-1];
    end
  end

  // Entry storage; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      tgt_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      tgt_q  <= tgt_d;
    end
  end

  assign data = data_q;
  assign vld  = vld_q;
  assign tgt  = tgt_q;

endmodule

// File: rtl/vc_demux_pop.sv
// Pops the main FIFO and steers each word to VC0/VC1 by its top bit,
// stalling through a skid entry when the destination VC is full.
module vc_demux_pop
  import vc_demux_pop_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    main_data,
  input  logic             main_empty,
  input  logic             vc0_almost_full,
  input  logic             vc1_almost_full,
  input  logic             vc0_full,
  input  logic             vc1_full,
  output logic             main_pop,
  output logic [DW-1:0]    vc0_data,
  output logic [DW-1:0]    vc1_data,
  output logic             vc0_push,
  output logic             vc1_push,
  output logic [CNT_W-1:0] cnt_vc0,
  output logic [CNT_W-1:0] cnt_vc1,
  output logic             idle
);

  vc_state_e state_q, state_d;

  logic             pop_dly_q, pop_dly_d;
  logic [DW-1:0]    vc0_data_q, vc0_data_d;
  logic [DW-1:0]    vc1_data_q, vc1_data_d;
  logic             vc0_push_q, vc0_push_d;
  logic             vc1_push_q, vc1_push_d;
  logic [CNT_W-1:0] cnt_vc0_q, cnt_vc0_d;
  logic [CNT_W-1:0] cnt_vc1_q, cnt_vc1_d;

  logic          skid_load, skid_drain;
  logic [DW-1:0] skid_data;
  logic          skid_vld, skid_tgt;
  logic          in_full_c, skid_full_c;

  // Destination-full flags for the arriving word and for the held word.
  assign in_full_c   = main_data[DW-1] ? vc1_full : vc0_full;
  assign skid_full_c = skid_tgt ? vc1_full : vc0_full;

  vc_skid_reg #(.DW(DW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .drain     (skid_drain),
    .load_data (main_data),
    .data      (skid_data),
    .vld       (skid_vld),
    .tgt       (skid_tgt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: HOLD on a blocked arrival, leave HOLD once the skid word drains.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!main_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (pop_dly_q && in_full_c)        state_d = ST_HOLD;
        else if (main_empty && !pop_dly_q) state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (skid_vld && !skid_full_c) state_d = main_empty ? ST_IDLE : ST_ACTIVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: pop gating, routing of the arriving or held word, counters.
  always_comb begin
    main_pop   = 1'b0;
    vc0_data_d = '0;
    vc1_data_d = '0;
    vc0_push_d = 1'b0;
    vc1_push_d = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;

    // Destination unknown before the read, so both almost-full flags gate the pop;
    // a blocked arrival also suppresses the pop so only one word is ever in flight.
    main_pop = !reset && (state_q == ST_ACTIVE) && !main_empty &&
               !vc0_almost_full && !vc1_almost_full &&
               !(pop_dly_q && in_full_c);

    if (pop_dly_q) begin
      if (in_full_c) begin
        skid_load = 1'b1;
      end else if (main_data[DW-1]) begin
        vc1_data_d = main_data;
        vc1_push_d = 1'b1;
      end else begin
        vc0_data_d = main_data;
        vc0_push_d = 1'b1;
      end
    end else if (skid_vld && !skid_full_c) begin
      skid_drain = 1'b1;
      if (skid_tgt) begin
        vc1_data_d = skid_data;
        vc1_push_d = 1'b1;
      end else begin
        vc0_data_d = skid_data;
        vc0_push_d = 1'b1;
      end
    end

    pop_dly_d = main_pop;
    cnt_vc0_d = cnt_vc0_q + CNT_W'(vc0_push_d);
    cnt_vc1_d = cnt_vc1_q + CNT_W'(vc1_push_d);
  end

  // Registered datapath: in-flight flag, VC write ports, counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_dly_q  <= 1'b0;
      vc0_data_q <= '0;
      vc1_data_q <= '0;
      vc0_push_q <= 1'b0;
      vc1_push_q <= 1'b0;
      cnt_vc0_q  <= '0;
      cnt_vc1_q  <= '0;
    end else begin
      pop_dly_q  <= pop_dly_d;
      vc0_data_q <= vc0_data_d;
      vc1_data_q <= vc1_data_d;
      vc0_push_q <= vc0_push_d;
      vc1_push_q <= vc1_push_d;
      cnt_vc0_q  <= cnt_vc0_d;
      cnt_vc1_q  <= cnt_vc1_d;
    end
  end

  // A fresh arrival can never coincide with a held word.
  a_no_pop_in_hold : assert property (@(posedge clk) disable iff (reset)
    !(pop_dly_q && skid_vld));

  assign vc0_data = vc0_data_q;
  assign vc1_data = vc1_data_q;
  assign vc0_push = vc0_push_q;
  assign vc1_push = vc1_push_q;
  assign cnt_vc0  = cnt_vc0_q;
  assign cnt_vc1  = cnt_vc1_q;
  assign idle     = (state_q == ST_IDLE);

endmodule
